float_acc: RTL and testbench
============================

// Module: float_acc
// PURPOSE
// - Packet accumulator downstream of the 4-stage single-precision multiplier; consumes its product stream.
// - Sums every float of a packet (terminated by s_axi_last) and emits one float sum per packet; forms the reduce stage of a dot product.
// - Multi-cycle FSM adder: one input accepted every 4 cycles, with valid/ready handshakes on both sides.
// PARAMETERS
// - EN_ROUND  "true"  "true": round-half-up on guard bit after normalise; anything else: truncate.
// PORTS
// - clk         in   1   clock
// - rst_n       in   1   asynchronous reset, active low
// - valid_i     in   1   input product valid
// - ready_o     out  1   block can accept input
// - s_axi_last  in   1   input is the final element of the packet
// - op_in       in   32  IEEE-754 single product
// - flow_i      in   2   upstream flow flags {over, under} for this element
// - valid_o     out  1   packet sum valid
// - ready_i     in   1   downstream accepts sum
// - m_axi_last  out  1   always 1 when valid_o=1 (one beat per packet)
// - op_result   out  32  packet sum
// - flow        out  2   sticky {over, under}: OR of all flow_i in the packet plus this block's own events
// BEHAVIOUR
// - Reset: state=IDLE, acc=32'h0, valid_o=0, m_axi_last=0, op_result=0, flow=0; ready_o=1 after reset release.
// - FSM: IDLE -> ALIGN -> ADD -> NORM -> (last ? OUT : IDLE); OUT -> IDLE on valid_o&&ready_i.
// - IDLE: ready_o=1; on valid_i&&ready_o, capture op_in, s_axi_last, OR flow_i into sticky flags. ready_o=0 in all other states.
// - ALIGN: order operands by exponent; 27-bit mantissas {1,frac,3'b0}; shift smaller right by exp diff, saturating at 27 (operand becomes 0).
// - ADD: same sign -> add; else subtract smaller magnitude from larger, result sign = larger's sign. Equal magnitudes -> +0.
// - NORM: carry-out -> shift right 1, exp+1; else leading-one detect, left shift, exp-shift. Round per EN_ROUND using mantissa bit 2; rounding carry renormalises.
// - NORM writes acc. Biased exp >= 255 -> INF (sign kept), flow[1]=1. Biased exp <= 0 -> signed zero, flow[0]=1.
// - Special operands: exp==0 is treated as zero (denormals flushed). Any NaN, or INF+(-INF) -> canonical NaN 32'h7FC00000. Otherwise INF dominates.
// - Packet start: acc=+0, so a 1-element packet returns op_in (denormal input -> +0).
// - Latency: accept of last element at edge N -> valid_o=1 after edge N+3.
// - OUT: op_result=acc, flow stable while valid_o && !ready_i. On handshake: acc<=0, flags<=0, valid_o<=0.
// - ready_i is ignored outside OUT. No new input is taken until the sum is consumed.
// - s_axi_last is don't-care on cycles without a handshake.
// - rst_n assertion mid-packet or mid-OUT discards the partial sum; outputs return to reset values asynchronously.
// CONFIGURATION
// - FLOAT_ACC_COUNT_EN defined: adds output port elem_cnt [15:0], the number of elements accepted in the packet.
//   - elem_cnt is valid with valid_o, saturates at 16'hFFFF, clears on output handshake, and resets to 0.
// - FLOAT_ACC_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
// - 3F800000, 40000000, 40400000 (last on 3rd) -> op_result=40C00000, flow=00, valid_o 3 cycles after last accept.
// - 3F800000 + BF800000 (last) -> op_result=00000000, flow=00.
// - 7F7FFFFF + 7F7FFFFF (last) -> op_result=7F800000, flow=10.
// - 7F800000 + FF800000 (last) -> op_result=7FC00000. Separately, 1-element packet with flow_i=01 -> flow=01.
// - Hold ready_i=0 for 5 cycles in OUT -> op_result/valid_o stable, ready_o=0; the next packet is accepted 1 cycle after the handshake.
// - Assert rst_n low during ALIGN of a 2nd element -> all outputs reset; the next packet 40000000 (last) -> 40000000.

Source files
------------

// File: rtl/float_acc.sv
// -----------------------------------------------------------------------------
// float_acc
// Packet accumulator for IEEE-754 single-precision products. Every float of a
// packet (terminated by s_axi_last) is added into an internal accumulator and
// one sum is emitted per packet. One element is processed every 4 cycles by a
// small FSM: IDLE (accept) -> ALIGN -> ADD -> NORM -> IDLE, or -> OUT after the
// last element of a packet.
//
// Parameters
//   EN_ROUND    "true": round-half-up on the guard bit after normalise,
//               anything else: truncate.
// Optional build macro
//   FLOAT_ACC_COUNT_EN  adds output elem_cnt[15:0] (elements in the packet,
//                       saturating, valid with valid_o, cleared on handshake).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_i / ready_o   input element handshake
//   s_axi_last          input element closes the packet
//   op_in[31:0]         input float
//   flow_i[1:0]         upstream {over, under} flags for this element
//   valid_o / ready_i   packet sum handshake
//   m_axi_last          1 whenever valid_o is 1 (one beat per packet)
//   op_result[31:0]     packet sum
//   flow[1:0]           sticky {over, under} for the packet
// -----------------------------------------------------------------------------
module float_acc #(
    parameter string EN_ROUND = "true"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        s_axi_last,
    input  logic [31:0] op_in,
    input  logic [1:0]  flow_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        m_axi_last,
    output logic [31:0] op_result,
`ifdef FLOAT_ACC_COUNT_EN
    output logic [1:0]  flow,
    output logic [15:0] elem_cnt
`else
    output logic [1:0]  flow
`endif
);

    localparam bit RoundEn = (EN_ROUND == "true");

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAlign = 3'd1;
    localparam logic [2:0] StAdd   = 3'd2;
    localparam logic [2:0] StNorm  = 3'd3;
    localparam logic [2:0] StOut   = 3'd4;

    localparam logic [31:0] CanonNan = 32'h7FC0_0000;

    logic [2:0]  state_q, state_d;
    logic [31:0] op_q;
    logic        last_q;
    logic [31:0] acc_q;
    logic [1:0]  flags_q;
    logic        valid_q;

    // ALIGN -> ADD pipeline registers
    logic [7:0]  exp_q;
    logic [26:0] big_m_q, small_m_q;
    logic        big_s_q, small_s_q;
    logic        special_q;
    logic [31:0] special_val_q;

    // ADD -> NORM pipeline registers
    logic [27:0] sum_q;
    logic        sign_q;

    logic accept, handshake;
    assign accept    = valid_i && ready_o;
    assign handshake = valid_q && ready_i;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StAlign;
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  state_d = last_q ? StOut : StIdle;
            StOut:   if (ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- ALIGN
    logic [7:0]  a_exp, b_exp, al_exp, al_diff;
    logic [26:0] a_m, b_m, al_big_m, al_small_raw, al_small_m;
    logic        a_inf, b_inf, a_nan, b_nan, al_swap;
    logic        al_big_s, al_small_s, al_special;
    logic [31:0] al_special_val;

    always_comb begin
        a_exp = acc_q[30:23];
        b_exp = op_q[30:23];
        a_inf = (a_exp == 8'hFF) && (acc_q[22:0] == 23'd0);
        b_inf = (b_exp == 8'hFF) && (op_q[22:0] == 23'd0);
        a_nan = (a_exp == 8'hFF) && (acc_q[22:0] != 23'd0);
        b_nan = (b_exp == 8'hFF) && (op_q[22:0] != 23'd0);
        // exp==0 flushes to zero (denormals included)
        a_m = (a_exp == 8'd0) ? 27'd0 : {1'b1, acc_q[22:0], 3'b000};
        b_m = (b_exp == 8'd0) ? 27'd0 : {1'b1, op_q[22:0], 3'b000};

        al_swap      = b_exp > a_exp;
        al_exp       = al_swap ? b_exp : a_exp;
        al_diff      = al_swap ? (b_exp - a_exp) : (a_exp - b_exp);
        al_big_m     = al_swap ? b_m : a_m;
        al_small_raw = al_swap ? a_m : b_m;
        al_big_s     = al_swap ? op_q[31] : acc_q[31];
        al_small_s   = al_swap ? acc_q[31] : op_q[31];
        al_small_m   = (al_diff >= 8'd27) ? 27'd0 : (al_small_raw >> al_diff);

        al_special     = a_nan || b_nan || a_inf || b_inf;
        al_special_val = CanonNan;
        if (!(a_nan || b_nan || (a_inf && b_inf && (acc_q[31] != op_q[31])))) begin
            al_special_val = a_inf ? {acc_q[31], 8'hFF, 23'd0} : {op_q[31], 8'hFF, 23'd0};
        end
    end

    // ------------------------------------------------------------------ ADD
    logic [27:0] ad_sum;
    logic        ad_sign;

    always_comb begin
        if (big_s_q == small_s_q) begin
            ad_sum  = {1'b0, big_m_q} + {1'b0, small_m_q};
            ad_sign = big_s_q;
        end else if (big_m_q >= small_m_q) begin
            ad_sum  = {1'b0, big_m_q} - {1'b0, small_m_q};
            ad_sign = big_s_q;
        end else begin
            // equal exponents, operand order by magnitude was unknown in ALIGN
            ad_sum  = {1'b0, small_m_q} - {1'b0, big_m_q};
            ad_sign = small_s_q;
        end
    end

    // ----------------------------------------------------------------- NORM
    logic [4:0]        nm_lz;
    logic              nm_found;
    logic [26:0]       nm_shifted;
    logic [24:0]       nm_pre;   // 24-bit mantissa + guard bit
    logic [24:0]       nm_rnd;
    logic [22:0]       nm_frac;
    logic signed [9:0] nm_exp;
    logic [31:0]       nm_acc;
    logic [1:0]        nm_flags;

    always_comb begin
        nm_lz    = 5'd0;
        nm_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!nm_found && sum_q[i]) begin
                nm_lz    = 5'(26 - i);
                nm_found = 1'b1;
            end
        end
        nm_shifted = sum_q[26:0] << nm_lz;

        if (sum_q[27]) begin
            nm_pre = sum_q[27:3];
            nm_exp = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            nm_pre = 25'(nm_shifted >> 2);
            nm_exp = $signed({2'b00, exp_q}) - $signed({5'b00000, nm_lz});
        end

        nm_rnd = {1'b0, nm_pre[24:1]} + {24'd0, (RoundEn && nm_pre[0])};
        if (nm_rnd[24]) begin
            // rounding overflowed to 2.0: renormalise
            nm_frac = nm_rnd[23:1];
            nm_exp  = nm_exp + 10'sd1;
        end else begin
            nm_frac = nm_rnd[22:0];
        end

        nm_flags = 2'b00;
        if (special_q) begin
            nm_acc = special_val_q;
        end else if (sum_q == 28'd0) begin
            nm_acc = 32'd0;
        end else if (nm_exp >= 10'sd255) begin
            nm_acc   = {sign_q, 8'hFF, 23'd0};
            nm_flags = 2'b10;
        end else if (nm_exp <= 10'sd0) begin
            nm_acc   = {sign_q, 31'd0};
            nm_flags = 2'b01;
        end else begin
            nm_acc = {sign_q, nm_exp[7:0], nm_frac};
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= 32'd0;
            last_q        <= 1'b0;
            acc_q         <= 32'd0;
            flags_q       <= 2'b00;
            valid_q       <= 1'b0;
            exp_q         <= 8'd0;
            big_m_q       <= 27'd0;
            small_m_q     <= 27'd0;
            big_s_q       <= 1'b0;
            small_s_q     <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= 32'd0;
            sum_q         <= 28'd0;
            sign_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= op_in;
                        last_q  <= s_axi_last;
                        flags_q <= flags_q | flow_i;
                    end
                end
                StAlign: begin
                    exp_q         <= al_exp;
                    big_m_q       <= al_big_m;
                    small_m_q     <= al_small_m;
                    big_s_q       <= al_big_s;
                    small_s_q     <= al_small_s;
                    special_q     <= al_special;
                    special_val_q <= al_special_val;
                end
                StAdd: begin
                    sum_q  <= ad_sum;
                    sign_q <= ad_sign;
                end
                StNorm: begin
                    acc_q   <= nm_acc;
                    flags_q <= flags_q | nm_flags;
                    if (last_q) valid_q <= 1'b1;
                end
                StOut: begin
                    if (handshake) begin
                        acc_q   <= 32'd0;
                        flags_q <= 2'b00;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FLOAT_ACC_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else if (handshake) begin
            cnt_q <= 16'd0;
        end else if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign elem_cnt = cnt_q;
`endif

    assign ready_o    = (state_q == StIdle);
    assign valid_o    = valid_q;
    assign m_axi_last = valid_q;
    assign op_result  = acc_q;
    assign flow       = flags_q;

endmodule

// File: tb/tb_float_acc.sv
// -----------------------------------------------------------------------------
// tb_float_acc
// Self-checking bench for float_acc: a table of packets (up to 3 elements)
// with hand-computed sums and flags, followed by directed sequences for
// output back-pressure and mid-packet reset.
// -----------------------------------------------------------------------------
module tb_float_acc;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic        s_axi_last;
    logic [31:0] op_in;
    logic [1:0]  flow_i;
    logic        valid_o;
    logic        ready_i;
    logic        m_axi_last;
    logic [31:0] op_result;
    logic [1:0]  flow;

    int errors = 0;
    int checks = 0;

    float_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .s_axi_last (s_axi_last),
        .op_in      (op_in),
        .flow_i     (flow_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .m_axi_last (m_axi_last),
        .op_result  (op_result),
        .flow       (flow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic [2:0][31:0] op;
        logic [2:0][1:0]  fl;
        logic [31:0]      res;
        logic [1:0]       fw;
    } vec_t;

    localparam int NumVec = 12;
    vec_t vecs[NumVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int n,
                           input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [1:0] f0, input logic [1:0] f1, input logic [1:0] f2,
                           input logic [31:0] res, input logic [1:0] fw);
        vecs[idx].n     = n;
        vecs[idx].op[0] = o0;
        vecs[idx].op[1] = o1;
        vecs[idx].op[2] = o2;
        vecs[idx].fl[0] = f0;
        vecs[idx].fl[1] = f1;
        vecs[idx].fl[2] = f2;
        vecs[idx].res   = res;
        vecs[idx].fw    = fw;
    endtask

    // Wait (bounded) for ready_o, then present one element for one edge.
    task automatic send(input logic [31:0] op, input logic [1:0] fl, input logic last,
                        output int waited);
        waited = 0;
        while (!ready_o && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: got ready_o=0 for %0d cycles, expected 1", waited);
        end
        valid_i    = 1'b1;
        op_in      = op;
        flow_i     = fl;
        s_axi_last = last;
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        s_axi_last = 1'b0;
        flow_i     = 2'b00;
        op_in      = 32'hDEAD_BEEF;
    endtask

    // Count edges from the last accept until valid_o rises (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!valid_o && lat < 20);
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
    endtask

    initial begin
        int w;
        int lat;

        rst_n      = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        s_axi_last = 1'b0;
        op_in      = 32'd0;
        flow_i     = 2'b00;

        set_vec(0,  3, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 2'b00, 2'b00,
                32'h40C00000, 2'b00);
        set_vec(1,  2, 32'h3F800000, 32'hBF800000, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h00000000, 2'b00);
        set_vec(2,  2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h7F800000, 2'b10);
        set_vec(3,  2, 32'h7F800000, 32'hFF800000, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h7FC00000, 2'b00);
        set_vec(4,  1, 32'h3F800000, 32'h0, 32'h0, 2'b01, 2'b00, 2'b00,
                32'h3F800000, 2'b01);
        // guard bit set -> round up
        set_vec(5,  2, 32'h3F800000, 32'h33800000, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h3F800001, 2'b00);
        // rounding carry renormalises to 2.0
        set_vec(6,  2, 32'h3FFFFFFF, 32'h33800000, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h40000000, 2'b00);
        // cancellation below min normal -> +0 with underflow
        set_vec(7,  2, 32'h00C00000, 32'h80800000, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h00000000, 2'b01);
        // denormal input flushed
        set_vec(8,  1, 32'h00400000, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h00000000, 2'b00);
        set_vec(9,  2, 32'h3F800000, 32'hC0000000, 32'h0, 2'b00, 2'b00, 2'b00,
                32'hBF800000, 2'b00);
        set_vec(10, 2, 32'h7FC00001, 32'h3F800000, 32'h0, 2'b00, 2'b00, 2'b00,
                32'h7FC00000, 2'b00);
        set_vec(11, 2, 32'h3F800000, 32'h3F800000, 32'h0, 2'b10, 2'b01, 2'b00,
                32'h40000000, 2'b11);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        check("reset_valid_o", {31'd0, valid_o}, 32'd0);
        check("reset_m_axi_last", {31'd0, m_axi_last}, 32'd0);
        check("reset_op_result", op_result, 32'd0);
        check("reset_flow", {30'd0, flow}, 32'd0);
        check("reset_ready_o", {31'd0, ready_o}, 32'd1);

        for (int v = 0; v < NumVec; v++) begin
            for (int e = 0; e < vecs[v].n; e++) begin
                send(vecs[v].op[e], vecs[v].fl[e], (e == vecs[v].n - 1), w);
            end
            wait_result(lat);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
            check($sformatf("vec%0d_op_result", v), op_result, vecs[v].res);
            check($sformatf("vec%0d_flow", v), {30'd0, flow}, {30'd0, vecs[v].fw});
            check($sformatf("vec%0d_m_axi_last", v), {31'd0, m_axi_last}, 32'd1);
            consume();
            check($sformatf("vec%0d_valid_clear", v), {31'd0, valid_o}, 32'd0);
        end

        // Back-pressure: sum held stable while ready_i is low.
        send(32'h40400000, 2'b00, 1'b1, w);
        wait_result(lat);
        check("hold_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid_o", c), {31'd0, valid_o}, 32'd1);
            check($sformatf("hold%0d_op_result", c), op_result, 32'h40400000);
            check($sformatf("hold%0d_ready_o", c), {31'd0, ready_o}, 32'd0);
        end
        consume();
        check("hold_ready_after_hs", {31'd0, ready_o}, 32'd1);
        send(32'h3F800000, 2'b00, 1'b1, w);
        check("hold_next_accept_wait", 32'(w), 32'd0);
        wait_result(lat);
        check("hold_next_op_result", op_result, 32'h3F800000);
        check("hold_next_flow", {30'd0, flow}, 32'd0);
        consume();

        // Reset in ALIGN of the second element discards the partial packet.
        send(32'h3F800000, 2'b01, 1'b0, w);
        send(32'h40000000, 2'b00, 1'b0, w);
        check("pre_reset_flow", {30'd0, flow}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_o", {31'd0, valid_o}, 32'd0);
        check("midrst_m_axi_last", {31'd0, m_axi_last}, 32'd0);
        check("midrst_op_result", op_result, 32'd0);
        check("midrst_flow", {30'd0, flow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h40000000, 2'b00, 1'b1, w);
        wait_result(lat);
        check("postrst_latency", 32'(lat), 32'd3);
        check("postrst_op_result", op_result, 32'h40000000);
        check("postrst_flow", {30'd0, flow}, 32'd0);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
